// File: rtl/gate_check_pkg.sv
// Shared types and constants for the gate_check_seq BIST sequencer.
package gate_check_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int N_IN_MAX   = 4;
   localparam int SETTLE_MAX = 15;

   // One extra bit so that a run where every vector fails still fits.
   function automatic int err_count_w(input int n_in);
      return n_in + 1;
   endfunction

endpackage

// File: rtl/gate_check_seq_settle_timer.sv
// Loadable down-counter pacing the settle wait between vector launch and sample.
module settle_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_value,
   input  logic         en,
   output logic [W-1:0] value,
   output logic         expired
);

   logic [W-1:0] value_r;

   // Counter register: load has priority, decrement saturates at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_r <= {W{1'b0}};
      end else if (load) begin
         value_r <= load_value;
      end else if (en && (value_r != {W{1'b0}})) begin
         value_r <= value_r - {{(W-1){1'b0}}, 1'b1};
      end else begin
         value_r <= value_r;
      end
   end

   assign value   = value_r;
   assign expired = (value_r == {W{1'b0}});

endmodule

// File: rtl/gate_check_seq.sv
// Exhaustive truth-table checker for a small combinational gate under test.
module gate_check_seq
   import gate_check_pkg::*;
#(
   parameter int N_IN   = 1,
   parameter int SETTLE = 0
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               start,
   input  logic                               abort,
   input  logic [2**N_IN-1:0]                 truth_table,
   output logic [N_IN-1:0]                    dut_a,
   input  logic                               dut_f,
   output logic                               busy,
   output logic                               done,
   output logic                               pass,
   output logic [err_count_w(N_IN)-1:0]       err_count,
   output logic [N_IN-1:0]                    first_fail_vec,
   output logic                               first_fail_valid
);

   localparam int               NV          = 2**N_IN;
   localparam int               EW          = err_count_w(N_IN);
   localparam logic [N_IN-1:0]  LAST_VEC    = N_IN'(NV - 1);
   localparam logic [N_IN-1:0]  ONE_VEC     = N_IN'(1);
   localparam logic             HAS_SETTLE  = (SETTLE > 0) ? 1'b1 : 1'b0;
   // WAIT lasts SETTLE cycles, so the timer starts one below.
   localparam logic [3:0]       SETTLE_LOAD = 4'((SETTLE > 0) ? (SETTLE - 1) : 0);

   state_t            state_r, state_s;
   logic [NV-1:0]     tt_r, tt_s;
   logic [N_IN-1:0]   vec_r, vec_s;
   logic [N_IN-1:0]   dut_a_r, dut_a_s;
   logic              busy_r, busy_s;
   logic              done_r, done_s;
   logic              pass_r, pass_s;
   logic [EW-1:0]     err_r, err_s;
   logic [EW-1:0]     err_inc_s;
   logic [N_IN-1:0]   ffv_r, ffv_s;
   logic              ffvld_r, ffvld_s;
   logic              mismatch_s;
   logic              tmr_load_s;
   logic              tmr_en_s;
   logic [3:0]        tmr_value_s;
   logic              tmr_expired_s;

   settle_timer #(.W(4)) u_settle_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (tmr_load_s),
      .load_value (SETTLE_LOAD),
      .en         (tmr_en_s),
      .value      (tmr_value_s),
      .expired    (tmr_expired_s)
   );

   assign mismatch_s = (dut_f != tt_r[vec_r]);
   assign err_inc_s  = err_r + {{(EW-1){1'b0}}, mismatch_s};

   // Next-state and next-output logic for the sequencer.
   always_comb begin
      state_s    = state_r;
      tt_s       = tt_r;
      vec_s      = vec_r;
      dut_a_s    = dut_a_r;
      busy_s     = busy_r;
      done_s     = 1'b0;
      pass_s     = pass_r;
      err_s      = err_r;
      ffv_s      = ffv_r;
      ffvld_s    = ffvld_r;
      tmr_load_s = 1'b0;
      tmr_en_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               tt_s    = truth_table;
               err_s   = {EW{1'b0}};
               pass_s  = 1'b0;
               ffv_s   = {N_IN{1'b0}};
               ffvld_s = 1'b0;
               vec_s   = {N_IN{1'b0}};
               dut_a_s = {N_IN{1'b0}};
               busy_s  = 1'b1;
               if (HAS_SETTLE) begin
                  state_s    = WAIT;
                  tmr_load_s = 1'b1;
               end else begin
                  state_s = CHECK;
               end
            end else begin
               state_s = IDLE;
            end
         end
         WAIT: begin
            if (abort) begin
               state_s = IDLE;
               busy_s  = 1'b0;
               dut_a_s = {N_IN{1'b0}};
            end else if (tmr_expired_s) begin
               state_s = CHECK;
            end else begin
               tmr_en_s = (tmr_value_s != 4'd0);
            end
         end
         CHECK: begin
            if (abort) begin
               state_s = IDLE;
               busy_s  = 1'b0;
               dut_a_s = {N_IN{1'b0}};
            end else begin
               err_s = err_inc_s;
               if (mismatch_s && !ffvld_r) begin
                  ffv_s   = vec_r;
                  ffvld_s = 1'b1;
               end else begin
                  ffv_s   = ffv_r;
                  ffvld_s = ffvld_r;
               end
               if (vec_r == LAST_VEC) begin
                  state_s = DONE;
                  done_s  = 1'b1;
                  busy_s  = 1'b0;
                  dut_a_s = {N_IN{1'b0}};
                  pass_s  = (err_inc_s == {EW{1'b0}});
               end else begin
                  vec_s   = vec_r + ONE_VEC;
                  dut_a_s = vec_r + ONE_VEC;
                  if (HAS_SETTLE) begin
                     state_s    = WAIT;
                     tmr_load_s = 1'b1;
                  end else begin
                     state_s = CHECK;
                  end
               end
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
            busy_s  = 1'b0;
            dut_a_s = {N_IN{1'b0}};
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         tt_r    <= {NV{1'b0}};
         vec_r   <= {N_IN{1'b0}};
         dut_a_r <= {N_IN{1'b0}};
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         pass_r  <= 1'b0;
         err_r   <= {EW{1'b0}};
         ffv_r   <= {N_IN{1'b0}};
         ffvld_r <= 1'b0;
      end else begin
         state_r <= state_s;
         tt_r    <= tt_s;
         vec_r   <= vec_s;
         dut_a_r <= dut_a_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
         pass_r  <= pass_s;
         err_r   <= err_s;
         ffv_r   <= ffv_s;
         ffvld_r <= ffvld_s;
      end
   end

   assign dut_a            = dut_a_r;
   assign busy             = busy_r;
   assign done             = done_r;
   assign pass             = pass_r;
   assign err_count        = err_r;
   assign first_fail_vec   = ffv_r;
   assign first_fail_valid = ffvld_r;

endmodule

// File: tb/tb_gate_check_seq.sv
// Bench for gate_check_seq: a 1-input/no-settle and a 2-input/settle-2 instance.
module tb_gate_check_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       abort = 1'b0;
   logic [3:0] tt_in = 4'd0;
   logic       start1 = 1'b0, start2 = 1'b0;
   logic [1:0] gate1 = 2'd0;
   logic [3:0] gate2 = 4'd0;
   int         sel_r = 0;

   logic [0:0] dut_a1;
   logic [1:0] dut_a2;
   logic       busy1, done1, pass1, ffvld1, busy2, done2, pass2, ffvld2;
   logic [1:0] err1;
   logic [2:0] err2;
   logic [0:0] ffv1;
   logic [1:0] ffv2;
   logic       dut_f1, dut_f2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign dut_f1 = gate1[dut_a1];
   assign dut_f2 = gate2[dut_a2];

   gate_check_seq #(.N_IN(1), .SETTLE(0)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort),
      .truth_table(tt_in[1:0]), .dut_a(dut_a1), .dut_f(dut_f1),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
      .first_fail_vec(ffv1), .first_fail_valid(ffvld1));

   gate_check_seq #(.N_IN(2), .SETTLE(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort),
      .truth_table(tt_in), .dut_a(dut_a2), .dut_f(dut_f2),
      .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
      .first_fail_vec(ffv2), .first_fail_valid(ffvld2));

   logic c_busy, c_done, c_pass, c_ffvld;
   int   c_dut_a, c_err, c_ffv;

   always_comb begin
      if (sel_r == 1) begin
         c_busy = busy2; c_done = done2; c_pass = pass2; c_ffvld = ffvld2;
         c_dut_a = int'(dut_a2); c_err = int'(err2); c_ffv = int'(ffv2);
      end else begin
         c_busy = busy1; c_done = done1; c_pass = pass1; c_ffvld = ffvld1;
         c_dut_a = int'(dut_a1); c_err = int'(err1); c_ffv = int'(ffv1);
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: a mismatch is any vector where the gate disagrees with the table.
   task automatic model(input int sel, input logic [3:0] g, input logic [3:0] t,
                        output int e, output int f);
      int nv;
      nv = (sel == 1) ? 4 : 2;
      e = 0;
      f = 0;
      for (int v = nv - 1; v >= 0; v--) begin
         if (g[v] != t[v]) begin
            e++;
            f = v;
         end
      end
   endtask

   task automatic set_start(input int sel, input logic val);
      if (sel == 1) start2 = val;
      else start1 = val;
   endtask

   task automatic run(input int sel, input logic [3:0] gate, input logic [3:0] tt,
                      input int exp_err, input int exp_ffv,
                      input int dist_k, input int abort_k, input int rst_k);
      int s, lat, done_k, ndone, seq_ok, busy_ok;
      s = (sel == 1) ? 2 : 0;
      lat = ((sel == 1) ? 4 : 2) * (s + 1);
      @(negedge clk);
      sel_r = sel;
      if (sel == 1) gate2 = gate;
      else gate1 = gate[1:0];
      tt_in = tt;
      set_start(sel, 1'b1);
      @(posedge clk);
      @(negedge clk);
      set_start(sel, 1'b0);
      chk("start_busy", int'(c_busy), 1);
      chk("start_dut_a", c_dut_a, 0);
      done_k = -1; ndone = 0; seq_ok = 1; busy_ok = 1;
      for (int k = 1; k <= lat + 20; k++) begin
         @(negedge clk);
         if (c_done) begin
            ndone++;
            if (done_k < 0) done_k = k;
         end
         if (k < lat && (abort_k < 0 || k <= abort_k)) begin
            if (c_dut_a != k / (s + 1)) seq_ok = 0;
            if (c_busy != 1'b1) busy_ok = 0;
         end
         if (abort_k >= 0 && k == abort_k + 1) begin
            chk("abort_busy", int'(c_busy), 0);
            chk("abort_dut_a", c_dut_a, 0);
            chk("abort_pass", int'(c_pass), 0);
            chk("abort_err_kept", c_err, exp_err);
            chk("abort_ffvld_kept", int'(c_ffvld), (exp_err > 0) ? 1 : 0);
         end
         set_start(sel, (k == dist_k) ? 1'b1 : 1'b0);
         if (k == dist_k) tt_in = ~tt;
         abort = (k == abort_k) ? 1'b1 : 1'b0;
         if (k == rst_k) begin
            rst_n = 1'b0;
            #1;
            chk("midrun_reset_outs",
                int'({busy2, done2, pass2, err2, ffv2, ffvld2, dut_a2}), 0);
            chk("midrun_reset_nodone", ndone, 0);
            #1;
            rst_n = 1'b1;
            set_start(sel, 1'b0);
            break;
         end
      end
      abort = 1'b0;
      if (rst_k < 0) begin
         chk("dut_a_sequence", seq_ok, 1);
         chk("busy_during_run", busy_ok, 1);
      end
      if (abort_k >= 0) begin
         chk("abort_no_done", ndone, 0);
      end else if (rst_k < 0) begin
         chk("done_latency", done_k, lat);
         chk("done_count", ndone, 1);
         chk("pass", int'(c_pass), (exp_err == 0) ? 1 : 0);
         chk("err_count", c_err, exp_err);
         chk("ffvld", int'(c_ffvld), (exp_err > 0) ? 1 : 0);
         if (exp_err > 0) chk("first_fail_vec", c_ffv, exp_ffv);
         chk("idle_busy", int'(c_busy), 0);
         chk("idle_dut_a", c_dut_a, 0);
      end
   endtask

   typedef struct {
      int         sel;
      logic [3:0] gate;
      logic [3:0] tt;
      int         exp_err;
      int         exp_ffv;
   } vec_t;

   vec_t tbl[11];

   initial begin
      int e, f, sel;
      logic [3:0] g, t;
      // NOT gate: f(0)=1, f(1)=0 is bit pattern 2'b01.
      tbl[0] = '{0, 4'b0001, 4'b0001, 0, 0};
      tbl[1] = '{0, 4'b0001, 4'b0010, 2, 0};
      tbl[2] = '{1, 4'b0000, 4'b1000, 1, 3};
      tbl[3] = '{1, 4'b1110, 4'b1110, 0, 0};
      tbl[4] = '{1, 4'b0110, 4'b1000, 3, 1};
      for (int i = 5; i < 11; i++) begin
         sel = int'($urandom_range(1, 0));
         g = 4'($urandom);
         t = 4'($urandom);
         if (sel == 0) begin
            g = g & 4'b0011;
            t = t & 4'b0011;
         end
         model(sel, g, t, e, f);
         tbl[i] = '{sel, g, t, e, f};
      end

      #12;
      chk("reset_outs_1", int'({busy1, done1, pass1, err1, ffv1, ffvld1, dut_a1}), 0);
      chk("reset_outs_2", int'({busy2, done2, pass2, err2, ffv2, ffvld2, dut_a2}), 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         run(tbl[i].sel, tbl[i].gate, tbl[i].tt, tbl[i].exp_err, tbl[i].exp_ffv, -1, -1, -1);
      end

      // Restart attempt and table change mid-run must be ignored.
      run(1, 4'b1000, 4'b1000, 0, 0, 3, -1, -1);
      // Abort after vector 0 was sampled: one mismatch retained.
      run(1, 4'b0000, 4'b0001, 1, 0, -1, 3, -1);
      run(1, 4'b1000, 4'b1000, 0, 0, -1, -1, -1);
      // Asynchronous reset mid-run, then a clean run.
      run(1, 4'b1000, 4'b1000, 0, 0, -1, -1, 5);
      run(1, 4'b1000, 4'b1000, 0, 0, -1, -1, -1);
      run(0, 4'b0001, 4'b0001, 0, 0, -1, -1, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
